wb_arbiter2: RTL and testbench
==============================

// Module: wb_arbiter2
// PURPOSE
//  Two-master Wishbone classic arbiter. Merges the core's instruction port (m0) and
//  data port (m1) onto the single shared RAM slave port (s), directly upstream of wb_ram.
//  Arbitrates per bus cycle and routes ack/rdata back to the owning master only.
//  A watchdog terminates hung cycles with err.
// PARAMETERS
//  FIXED_PRIO  0     0: round-robin; 1: m0 (instruction) always wins a tie
//  TIMEOUT     1024  cycles of stb without ack before err; 0 disables the watchdog
// PORTS
//  clk       in   1   system clock; single clock domain
//  reset     in   1   synchronous, active-high reset
//  m0_addr   in   32  instruction master address
//  m0_wdata  in   32  instruction master write data
//  m0_sel    in   4   instruction master byte selects
//  m0_we     in   1   instruction master write enable
//  m0_cyc    in   1   instruction master bus-cycle request
//  m0_stb    in   1   instruction master strobe
//  m0_rdata  out  32  read data returned to m0
//  m0_ack    out  1   transfer acknowledge to m0
//  m0_err    out  1   watchdog error to m0
//  m1_*      same set as m0_* for the data master
//  s_addr    out  32  address to slave
//  s_wdata   out  32  write data to slave
//  s_sel     out  4   byte selects to slave
//  s_we      out  1   write enable to slave
//  s_cyc     out  1   bus cycle to slave
//  s_stb     out  1   strobe to slave
//  s_rdata   in   32  read data from slave
//  s_ack     in   1   acknowledge from slave
// BEHAVIOUR
//  - FSM states: IDLE, GNT0, GNT1 (registered). Reset -> IDLE; last_gnt <= 1, so m0 wins
//    the first tie.
//  - IDLE: if any mN_cyc, register a grant; one cycle of arbitration latency.
//    Tie: FIXED_PRIO=1 -> GNT0; FIXED_PRIO=0 -> the master != last_gnt.
//    Single requester -> that master.
//  - GNTn: s_* = mN_* combinationally; s_cyc = mN_cyc, s_stb = mN_stb.
//    Return path: mN_ack = s_ack, mN_rdata = s_rdata. The other master sees ack=0,
//    err=0, rdata=0.
//  - Grant is held while mN_cyc=1, spanning multiple stb/ack beats.
//    When mN_cyc falls: -> IDLE, last_gnt <= n. No back-to-back grant in the same cycle;
//    the IDLE cycle guarantees s_cyc=0 for >=1 cycle between owners.
//  - IDLE outputs: s_cyc=s_stb=s_we=0, s_addr=s_wdata=0, s_sel=0, all mN_ack/err=0.
//  - s_ack arriving in IDLE (stale, e.g. after a timeout) is discarded and never forwarded.
//  - Watchdog (TIMEOUT>0):
//    - Counter clears on IDLE, on s_ack, or when the granted stb=0.
//    - Counter increments while granted stb=1 and s_ack=0.
//    - At count == TIMEOUT-1: mN_err=1 for exactly one cycle. s_cyc and s_stb are forced
//      to 0 that cycle. FSM -> IDLE next cycle, last_gnt <= n.
//    - Counter width $clog2(TIMEOUT+1); it saturates and never wraps.
//  - Simultaneous s_ack and timeout in the same cycle: ack wins, no err.
//  - Reset asserted mid-cycle: next edge forces IDLE and all outputs to the IDLE values.
//    Any in-flight slave ack is dropped.
//  - All registers are reset synchronously; no async reset and no latches.
// STRUCTURE
//  - wb_pkg: state encoding (IDLE=2'd0, GNT0=2'd1, GNT1=2'd2) and master index constants
//    M_INST=1'b0, M_DATA=1'b1.
//  - Sub-module wb_arb_timer: watchdog counter with inputs clr, run and output expire,
//    parameter TIMEOUT.
//  - Top level: FSM, last_gnt register, and the muxes.
// TESTING
//  1. Only m0_cyc/stb=1 read at addr 0x10; slave acks 2 cycles later with 0xDEADBEEF
//     -> s_cyc rises 1 cycle after request; m0_ack=1 with m0_rdata=0xDEADBEEF; m1_ack=0.
//  2. m0 and m1 request in the same cycle, FIXED_PRIO=0, held for 4 transactions
//     -> grants alternate m0, m1, m0, m1; s_cyc=0 for exactly 1 cycle between owners.
//  3. Same as 2 with FIXED_PRIO=1 -> m0 is served on every tie; m1 only when m0_cyc=0.
//  4. m1 write with s_sel=4'b0011, m1 holds cyc across 3 stb/ack beats while m0 requests
//     -> m0 is not granted until m1_cyc falls; s_we/s_sel track m1 exactly.
//  5. TIMEOUT=8, slave never acks -> m1_err=1 on the 8th stb cycle, s_cyc=0 that cycle,
//     IDLE next; a late s_ack is not forwarded.
//  6. Reset pulsed for 1 cycle during GNT0 with ack pending -> all outputs 0 the next
//     cycle; the pending ack is dropped; a fresh tie after reset grants m0.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared encodings for the two-master Wishbone arbiter.
package wb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } arb_state_t;

  localparam logic M_INST = 1'b0;
  localparam logic M_DATA = 1'b1;

  // Winner of a simultaneous request: fixed priority favours the instruction port.
  function automatic logic tie_winner(input bit fixed_prio, input logic last_gnt);
    return fixed_prio ? M_INST : ~last_gnt;
  endfunction

endpackage

// File: rtl/wb_arb_timer.sv
// Watchdog for a granted bus cycle: counts strobe cycles without ack, saturating.
module wb_arb_timer #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic run,
  output logic expire
);

  localparam int W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [W-1:0] LAST = W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [W-1:0] SAT  = W'(TIMEOUT);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || clr)
      cnt <= '0;
    else if (run && cnt != SAT)
      cnt <= cnt + W'(1);
  end

  // TIMEOUT == 0 disables the watchdog entirely.
  assign expire = (TIMEOUT > 0) && run && (cnt == LAST);

endmodule

// File: rtl/wb_arbiter2.sv
// Two-master Wishbone classic arbiter in front of the shared RAM slave port.
module wb_arbiter2
  import wb_pkg::*;
#(
  parameter bit FIXED_PRIO = 1'b0,
  parameter int TIMEOUT    = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_sel,
  input  logic        m0_we,
  input  logic        m0_cyc,
  input  logic        m0_stb,
  output logic [31:0] m0_rdata,
  output logic        m0_ack,
  output logic        m0_err,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_sel,
  input  logic        m1_we,
  input  logic        m1_cyc,
  input  logic        m1_stb,
  output logic [31:0] m1_rdata,
  output logic        m1_ack,
  output logic        m1_err,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_sel,
  output logic        s_we,
  output logic        s_cyc,
  output logic        s_stb,
  input  logic [31:0] s_rdata,
  input  logic        s_ack
);

  arb_state_t state;
  logic       last_gnt;
  logic       gnt, own, g_cyc, g_stb, expire;

  assign gnt   = (state != IDLE);
  assign own   = (state == GNT1);
  assign g_cyc = own ? m1_cyc : m0_cyc;
  assign g_stb = own ? m1_stb : m0_stb;

  // An ack in the same cycle keeps run low, so a real ack always beats the timeout.
  wb_arb_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clr    (!gnt || s_ack || !g_stb),
    .run    (gnt && g_stb && !s_ack),
    .expire (expire)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      last_gnt <= M_DATA;
    end else begin
      case (state)
        IDLE: begin
          if (m0_cyc && m1_cyc)
            state <= (tie_winner(FIXED_PRIO, last_gnt) == M_INST) ? GNT0 : GNT1;
          else if (m0_cyc)
            state <= GNT0;
          else if (m1_cyc)
            state <= GNT1;
        end
        GNT0, GNT1: begin
          // Always pass through IDLE so the slave sees cyc low between owners.
          if (expire || !g_cyc) begin
            state    <= IDLE;
            last_gnt <= own;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    s_addr   = '0;
    s_wdata  = '0;
    s_sel    = '0;
    s_we     = 1'b0;
    s_cyc    = 1'b0;
    s_stb    = 1'b0;
    m0_rdata = '0;
    m0_ack   = 1'b0;
    m0_err   = 1'b0;
    m1_rdata = '0;
    m1_ack   = 1'b0;
    m1_err   = 1'b0;
    if (gnt) begin
      s_addr  = own ? m1_addr  : m0_addr;
      s_wdata = own ? m1_wdata : m0_wdata;
      s_sel   = own ? m1_sel   : m0_sel;
      s_we    = own ? m1_we    : m0_we;
      s_cyc   = g_cyc && !expire;
      s_stb   = g_stb && !expire;
      if (own) begin
        m1_ack   = s_ack;
        m1_rdata = s_rdata;
        m1_err   = expire;
      end else begin
        m0_ack   = s_ack;
        m0_rdata = s_rdata;
        m0_err   = expire;
      end
    end
  end

endmodule

// File: tb/tb_wb_arbiter2.sv
// Directed bench: round-robin instance (a) and fixed-priority instance (b), both TIMEOUT=8.
module tb_wb_arbiter2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata, s_rdata;
  logic [3:0]  m0_sel, m1_sel;
  logic        m0_we, m0_cyc, m0_stb, m1_we, m1_cyc, m1_stb;
  logic        ack_a, ack_b;

  logic [31:0] a_m0_rdata, a_m1_rdata, a_s_addr, a_s_wdata;
  logic        a_m0_ack, a_m0_err, a_m1_ack, a_m1_err, a_s_we, a_s_cyc, a_s_stb;
  logic [3:0]  a_s_sel;
  logic [31:0] b_m0_rdata, b_m1_rdata, b_s_addr, b_s_wdata;
  logic        b_m0_ack, b_m0_err, b_m1_ack, b_m1_err, b_s_we, b_s_cyc, b_s_stb;
  logic [3:0]  b_s_sel;

  int   checks = 0;
  int   errors = 0;
  logic slv_en = 1'b0;
  logic stb_a_q, stb_b_q;

  always #5 clk = ~clk;

  wb_arbiter2 #(.FIXED_PRIO(1'b0), .TIMEOUT(8)) dut_a (
    .clk(clk), .reset(reset),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_sel(m0_sel), .m0_we(m0_we),
    .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_rdata(a_m0_rdata), .m0_ack(a_m0_ack), .m0_err(a_m0_err),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_sel(m1_sel), .m1_we(m1_we),
    .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_rdata(a_m1_rdata), .m1_ack(a_m1_ack), .m1_err(a_m1_err),
    .s_addr(a_s_addr), .s_wdata(a_s_wdata), .s_sel(a_s_sel), .s_we(a_s_we),
    .s_cyc(a_s_cyc), .s_stb(a_s_stb), .s_rdata(s_rdata), .s_ack(ack_a)
  );

  wb_arbiter2 #(.FIXED_PRIO(1'b1), .TIMEOUT(8)) dut_b (
    .clk(clk), .reset(reset),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_sel(m0_sel), .m0_we(m0_we),
    .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_rdata(b_m0_rdata), .m0_ack(b_m0_ack), .m0_err(b_m0_err),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_sel(m1_sel), .m1_we(m1_we),
    .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_rdata(b_m1_rdata), .m1_ack(b_m1_ack), .m1_err(b_m1_err),
    .s_addr(b_s_addr), .s_wdata(b_s_wdata), .s_sel(b_s_sel), .s_we(b_s_we),
    .s_cyc(b_s_cyc), .s_stb(b_s_stb), .s_rdata(s_rdata), .s_ack(ack_b)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // One clock; each slave model acks one cycle after it sees stb, for a single cycle.
  task automatic tick();
    #1;
    stb_a_q = a_s_stb;
    stb_b_q = b_s_stb;
    @(posedge clk);
    #1;
    ack_a = slv_en && stb_a_q && !ack_a;
    ack_b = slv_en && stb_b_q && !ack_b;
    #1;
  endtask

  task automatic idle_masters();
    m0_addr = '0; m0_wdata = '0; m0_sel = '0; m0_we = 1'b0; m0_cyc = 1'b0; m0_stb = 1'b0;
    m1_addr = '0; m1_wdata = '0; m1_sel = '0; m1_we = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    ack_a = 1'b0;
    ack_b = 1'b0;
  endtask

  // Both masters want two single-beat transfers each; log who gets acked, in order.
  task automatic contend(input bit use_b, input logic [3:0] exp_seq, input string nm);
    int         n0 = 0;
    int         n1 = 0;
    int         gap = 0;
    int         guard = 0;
    bit         started = 1'b0;
    logic [3:0] seq = '0;
    logic       sc, a0, a1;
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_addr = 32'h100;
    m1_cyc = 1'b1; m1_stb = 1'b1; m1_addr = 32'h200;
    slv_en = 1'b1;
    while ((n0 < 2 || n1 < 2) && guard < 80) begin
      tick();
      guard++;
      sc = use_b ? b_s_cyc  : a_s_cyc;
      a0 = use_b ? b_m0_ack : a_m0_ack;
      a1 = use_b ? b_m1_ack : a_m1_ack;
      if (sc) begin
        if (started && gap != 0) chk({nm, " gap"}, 32'(gap), 32'd1);
        gap = 0;
        started = 1'b1;
      end else if (started) begin
        gap++;
      end
      chk({nm, " dual ack"}, {31'd0, a0 && a1}, 32'd0);
      if (a0) begin
        seq = {seq[2:0], 1'b0}; n0++; m0_cyc = 1'b0; m0_stb = 1'b0;
      end else if (!m0_cyc && n0 < 2) begin
        m0_cyc = 1'b1; m0_stb = 1'b1;
      end
      if (a1) begin
        seq = {seq[2:0], 1'b1}; n1++; m1_cyc = 1'b0; m1_stb = 1'b0;
      end else if (!m1_cyc && n1 < 2) begin
        m1_cyc = 1'b1; m1_stb = 1'b1;
      end
    end
    chk({nm, " completed"}, {31'd0, guard < 80}, 32'd1);
    chk({nm, " order"}, {28'd0, seq}, {28'd0, exp_seq});
  endtask

  initial begin
    int beats;
    idle_masters();
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_addr = 32'h55;
    s_rdata = 32'hDEADBEEF;
    ack_a = 1'b0; ack_b = 1'b0;

    // Reset holds IDLE even with a live request.
    reset = 1'b1;
    tick();
    tick();
    chk("rst s_cyc",  {31'd0, a_s_cyc},  32'd0);
    chk("rst s_stb",  {31'd0, a_s_stb},  32'd0);
    chk("rst s_addr", a_s_addr,          32'd0);
    chk("rst m0_ack", {31'd0, a_m0_ack}, 32'd0);
    chk("rst b s_cyc", {31'd0, b_s_cyc}, 32'd0);
    reset = 1'b0;
    idle_masters();
    tick();

    // 1: single m0 read
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_addr = 32'h10; m0_sel = 4'hF; slv_en = 1'b1;
    #1;
    chk("t1 req cycle s_cyc", {31'd0, a_s_cyc}, 32'd0);
    tick();
    chk("t1 grant s_cyc",  {31'd0, a_s_cyc},  32'd1);
    chk("t1 grant s_addr", a_s_addr,          32'h10);
    chk("t1 early m0_ack", {31'd0, a_m0_ack}, 32'd0);
    tick();
    chk("t1 m0_ack",   {31'd0, a_m0_ack}, 32'd1);
    chk("t1 m0_rdata", a_m0_rdata,        32'hDEADBEEF);
    chk("t1 m1_ack",   {31'd0, a_m1_ack}, 32'd0);
    chk("t1 m1_rdata", a_m1_rdata,        32'd0);
    idle_masters();
    tick();

    // 2 and 3: contention, round-robin then fixed priority
    do_reset();
    contend(1'b0, 4'b0101, "rr");
    idle_masters();
    tick();
    do_reset();
    contend(1'b1, 4'b0011, "fp");
    idle_masters();
    tick();

    // 4: m1 multi-beat write holds off m0
    do_reset();
    slv_en = 1'b1;
    m1_cyc = 1'b1; m1_stb = 1'b1; m1_we = 1'b1; m1_sel = 4'b0011;
    m1_addr = 32'h20; m1_wdata = 32'h1111;
    tick();
    chk("t4 s_we",  {31'd0, a_s_we}, 32'd1);
    chk("t4 s_sel", {28'd0, a_s_sel}, 32'h3);
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_addr = 32'h40;
    beats = 0;
    for (int i = 0; i < 20 && beats < 3; i++) begin
      tick();
      chk("t4 owner addr", a_s_addr,          32'h20);
      chk("t4 s_sel hold", {28'd0, a_s_sel},  32'h3);
      chk("t4 s_wdata",    a_s_wdata,         m1_wdata);
      chk("t4 m0 no ack",  {31'd0, a_m0_ack}, 32'd0);
      if (a_m1_ack) begin
        beats++;
        m1_wdata = m1_wdata + 32'd1;
        if (beats == 3) begin
          m1_cyc = 1'b0; m1_stb = 1'b0;
        end
      end
    end
    chk("t4 beats", 32'(beats), 32'd3);
    tick();
    chk("t4 idle s_cyc", {31'd0, a_s_cyc}, 32'd0);
    tick();
    chk("t4 m0 s_cyc",  {31'd0, a_s_cyc}, 32'd1);
    chk("t4 m0 s_addr", a_s_addr,         32'h40);
    chk("t4 m0 s_we",   {31'd0, a_s_we},  32'd0);
    idle_masters();
    tick();

    // 5: watchdog fires on the 8th unacked strobe cycle; a late ack is discarded
    do_reset();
    slv_en = 1'b0;
    m1_cyc = 1'b1; m1_stb = 1'b1; m1_addr = 32'h30;
    for (int i = 1; i <= 7; i++) begin
      tick();
      chk("t5 pre err",   {31'd0, a_m1_err}, 32'd0);
      chk("t5 pre s_cyc", {31'd0, a_s_cyc},  32'd1);
    end
    tick();
    chk("t5 m1_err", {31'd0, a_m1_err}, 32'd1);
    chk("t5 s_cyc",  {31'd0, a_s_cyc},  32'd0);
    chk("t5 s_stb",  {31'd0, a_s_stb},  32'd0);
    chk("t5 m0_err", {31'd0, a_m0_err}, 32'd0);
    tick();
    chk("t5 err one cycle", {31'd0, a_m1_err}, 32'd0);
    chk("t5 idle s_cyc",    {31'd0, a_s_cyc},  32'd0);
    idle_masters();
    ack_a = 1'b1;
    #1;
    chk("t5 late m1_ack", {31'd0, a_m1_ack}, 32'd0);
    chk("t5 late m0_ack", {31'd0, a_m0_ack}, 32'd0);
    ack_a = 1'b0;
    tick();

    // ack arriving on the would-be timeout cycle wins
    do_reset();
    m1_cyc = 1'b1; m1_stb = 1'b1;
    repeat (8) tick();
    ack_a = 1'b1;
    #1;
    chk("t5b ack wins ack", {31'd0, a_m1_ack}, 32'd1);
    chk("t5b ack wins err", {31'd0, a_m1_err}, 32'd0);
    chk("t5b ack s_cyc",    {31'd0, a_s_cyc},  32'd1);
    idle_masters();
    ack_a = 1'b0;
    tick();

    // 6: reset mid-cycle drops the pending ack; next tie goes to m0
    do_reset();
    slv_en = 1'b1;
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_addr = 32'h60; m0_sel = 4'hF;
    tick();
    chk("t6 granted", {31'd0, a_s_cyc}, 32'd1);
    reset = 1'b1;
    tick();
    chk("t6 s_cyc",    {31'd0, a_s_cyc},  32'd0);
    chk("t6 s_stb",    {31'd0, a_s_stb},  32'd0);
    chk("t6 s_addr",   a_s_addr,          32'd0);
    chk("t6 s_sel",    {28'd0, a_s_sel},  32'd0);
    chk("t6 m0_ack",   {31'd0, a_m0_ack}, 32'd0);
    chk("t6 m0_rdata", a_m0_rdata,        32'd0);
    reset = 1'b0;
    slv_en = 1'b0;
    ack_a = 1'b0; ack_b = 1'b0;
    m1_cyc = 1'b1; m1_stb = 1'b1; m1_addr = 32'h70;
    tick();
    chk("t6 tie s_cyc",  {31'd0, a_s_cyc}, 32'd1);
    chk("t6 tie s_addr", a_s_addr,         32'h60);
    idle_masters();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
